// File: rtl/riscv_enc_pkg.sv
// rtl/riscv_enc_pkg.sv - RV32I encoder shared types, constants and immediate range helper
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    // True when bits [31:lsb] are all ones or all zeros, i.e. the value fits as a sign extension.
    function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << lsb;
        return ((v & mask) == mask) || ((v & mask) == 32'h0);
    endfunction

endpackage

// File: rtl/instr_enc_core.sv
// rtl/instr_enc_core.sv - combinational field packer with immediate legality check
module instr_enc_core
    import riscv_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    logic [31:0] word;
    logic        legal;

    always_comb begin
        word  = 32'h0;
        legal = 1'b0;
        case (fmt)
            FMT_R: begin
                word  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            FMT_I: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = upper_uniform(imm, 11);
            end
            FMT_S: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = upper_uniform(imm, 11);
            end
            FMT_B: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = upper_uniform(imm, 12) && !imm[0];
            end
            FMT_U: begin
                word  = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'h0);
            end
            FMT_J: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = upper_uniform(imm, 20) && !imm[0];
            end
            default: begin
                word  = 32'h0;
                legal = 1'b0;
            end
        endcase
        instr = legal ? word : NOP_INSTR;
        err   = !legal;
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I assembler with address sequencing and 2-entry output buffer
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [15:0]       err_count
);

    logic [31:0]       enc_instr;
    logic              enc_err;
    logic              accept;
    logic              pop;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] word_addr;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [31:0]       mem_instr [2];
    logic [ADDR_W-1:0] mem_addr  [2];
    logic              mem_err   [2];

    instr_enc_core u_core (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .instr  (enc_instr),
        .err    (enc_err)
    );

    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign word_addr = addr_clr ? BASE_ADDR : cnt;

    always_comb begin
        count_next = count;
        if (accept && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !accept) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_instr[i] <= 32'h0;
                mem_addr[i]  <= '0;
                mem_err[i]   <= 1'b0;
            end
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            in_ready  <= 1'b1;
            cnt       <= BASE_ADDR;
            err_count <= 16'h0;
        end else begin
            if (accept) begin
                mem_instr[wr_ptr] <= enc_instr;
                mem_addr[wr_ptr]  <= word_addr;
                mem_err[wr_ptr]   <= enc_err;
                wr_ptr            <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            count    <= count_next;
            // Registered ready: looks only at next occupancy, never at in_valid this cycle.
            in_ready <= (count_next != 2'd2);
            if (accept) begin
                cnt <= word_addr + ADDR_W'(4);
            end else if (addr_clr) begin
                cnt <= BASE_ADDR;
            end
            if (accept && enc_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_instr = mem_instr[rd_ptr];
    assign out_addr  = mem_addr[rd_ptr];
    assign out_err   = mem_err[rd_ptr];

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        addr_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [15:0] err_count;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_cnt = 32'h0;
    int          exp_errs = 0;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .addr_clr  (addr_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rdv,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = f; in_opcode = op; in_rd = rdv; in_rs1 = r1; in_rs2 = r2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rdv,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic clr,
                        input logic [31:0] ei, input logic ee, input logic chk);
        int   budget;
        exp_t e;
        @(negedge clk);
        set_fields(f, op, rdv, r1, r2, f3, f7, imm);
        in_valid = 1'b1;
        addr_clr = clr;
        budget = 0;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
            in_valid = 1'b0; addr_clr = 1'b0;
            return;
        end
        e.addr  = clr ? 32'h0 : exp_cnt;
        exp_cnt = e.addr + 32'd4;
        e.instr = ei; e.err = ee; e.chk = chk;
        if (ee) exp_errs++;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        addr_clr = 1'b0;
    endtask

    task automatic recv(output logic [31:0] i, output logic [31:0] a, output logic e, output logic ok);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        ok = out_valid; i = out_instr; a = out_addr; e = out_err;
        if (ok) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic check_word(input string name);
        logic [31:0] gi, ga;
        logic        ge, ok;
        exp_t        ex;
        recv(gi, ga, ge, ok);
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s unexpected word instr=%h (scoreboard empty)", name, gi);
            return;
        end
        ex = sb.pop_front();
        if (!ok || gi !== ex.instr || ga !== ex.addr || ge !== ex.err) begin
            n_bad++;
            $display("FAIL %s got valid=%b instr=%h addr=%h err=%b required instr=%h addr=%h err=%b",
                     name, ok, gi, ga, ge, ex.instr, ex.addr, ex.err);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || out_addr !== 32'h0 ||
            out_err !== 1'b0 || err_count !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_state valid=%b ready=%b instr=%h addr=%h err=%b cnt=%h required 0 1 0 0 0 0",
                     out_valid, in_ready, out_instr, out_addr, out_err, err_count);
        end
    endtask

    task automatic test_i_type();
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0093, 1'b0, 1'b1);
        check_word("i_neg1");
    endtask

    task automatic test_b_type();
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'hFE20_8EE3, 1'b0, 1'b1);
        check_word("b_neg4");
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFD, 1'b0, 32'h0000_0013, 1'b1, 1'b1);
        check_word("b_odd");
        n_cmp++;
        if (err_count !== 16'(exp_errs)) begin
            n_bad++;
            $display("FAIL b_err_count got=%0d required=%0d", err_count, exp_errs);
        end
    endtask

    task automatic test_range();
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h0000_0013, 1'b1, 1'b1);
        check_word("i_2048");
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, 1'b0, 32'h0000_0013, 1'b1, 1'b1);
        check_word("u_low_bits");
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, 32'h1234_52B7, 1'b0, 1'b1);
        check_word("u_lui");
        send(3'd6, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0, 1'b0, 32'h0000_0013, 1'b1, 1'b1);
        check_word("fmt6");
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 1'b0, 32'h8000_0113, 1'b0, 1'b1);
        check_word("i_min");
        n_cmp++;
        if (err_count !== 16'(exp_errs)) begin
            n_bad++;
            $display("FAIL range_err_count got=%0d required=%0d", err_count, exp_errs);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        exp_t        ex;
        out_ready = 1'b0;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b1, 32'h0010_0093, 1'b0, 1'b1);
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'h0020_0113, 1'b0, 1'b1);
        @(negedge clk);
        set_fields(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        in_valid = 1'b1;
        held = out_instr;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || out_instr !== held || out_instr !== 32'h0010_0093) begin
                n_bad++;
                $display("FAIL full_hold ready=%b instr=%h required ready=0 instr=00100093", in_ready, out_instr);
            end
        end
        out_ready = 1'b1;
        ex = sb.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || out_instr !== ex.instr || out_addr !== ex.addr) begin
            n_bad++;
            $display("FAIL drain0 instr=%h addr=%h required instr=%h addr=%h", out_instr, out_addr, ex.instr, ex.addr);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_pop got=%b required=1", in_ready);
        end
        ex.instr = 32'h0030_0193; ex.addr = exp_cnt; ex.err = 1'b0; ex.chk = 1'b1;
        exp_cnt = exp_cnt + 32'd4;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_word("drain1");
        check_word("drain2");
        send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 1'b1, 32'h0040_0213, 1'b0, 1'b1);
        check_word("clr_accept");
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'h0010_0093, 1'b0, 1'b1);
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'h0020_0113, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || err_count !== 16'h0) begin
            n_bad++;
            $display("FAIL async_reset valid=%b ready=%b instr=%h errs=%0d required 0 1 0 0",
                     out_valid, in_ready, out_instr, err_count);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_cnt = 32'h0;
        exp_errs = 0;
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 1'b0, 32'h4020_81B3, 1'b0, 1'b1);
        check_word("post_reset_r");
    endtask

    task automatic test_random();
        logic [31:0] t, imm, gi, ga, prev, ximm;
        logic [2:0]  f;
        logic [6:0]  op, f7;
        logic [4:0]  rdv, r1, r2;
        logic [2:0]  f3;
        logic        ge, ok, good;
        exp_t        ex;
        prev = exp_cnt - 32'd4;
        for (int n = 0; n < 10000; n++) begin
            t   = $urandom;
            f   = 3'($urandom_range(0, 5));
            op  = 7'($urandom); rdv = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
            f3  = 3'($urandom); f7 = 7'($urandom);
            case (f)
                3'd1, 3'd2: imm = {{20{t[11]}}, t[11:0]};
                3'd3:       imm = {{19{t[12]}}, t[12:1], 1'b0};
                3'd4:       imm = {t[31:12], 12'h0};
                3'd5:       imm = {{11{t[20]}}, t[20:1], 1'b0};
                default:    imm = t;
            endcase
            send(f, op, rdv, r1, r2, f3, f7, imm, 1'b0, 32'h0, 1'b0, 1'b0);
            recv(gi, ga, ge, ok);
            ex = sb.pop_front();
            case (f)
                3'd1:    ximm = {{20{gi[31]}}, gi[31:20]};
                3'd2:    ximm = {{20{gi[31]}}, gi[31:25], gi[11:7]};
                3'd3:    ximm = {{19{gi[31]}}, gi[31], gi[7], gi[30:25], gi[11:8], 1'b0};
                3'd4:    ximm = {gi[31:12], 12'h0};
                3'd5:    ximm = {{11{gi[31]}}, gi[31], gi[19:12], gi[20], gi[30:21], 1'b0};
                default: ximm = imm;
            endcase
            good = ok && !ge && gi[6:0] == op && ximm == imm && ga == ex.addr && ga == prev + 32'd4;
            if (f inside {3'd0, 3'd1, 3'd4, 3'd5}) good = good && gi[11:7] == rdv;
            if (f inside {3'd0, 3'd1, 3'd2, 3'd3}) good = good && gi[19:15] == r1 && gi[14:12] == f3;
            if (f inside {3'd0, 3'd2, 3'd3})       good = good && gi[24:20] == r2;
            if (f == 3'd0)                          good = good && gi[31:25] == f7;
            n_cmp++;
            if (!good) begin
                n_bad++;
                $display("FAIL rand#%0d fmt=%0d instr=%h addr=%h err=%b imm_back=%h required imm=%h addr=%h op=%h",
                         n, f, gi, ga, ge, ximm, imm, ex.addr, op);
            end
            prev = ga;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b0;
        set_fields(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_i_type();
        test_b_type();
        test_range();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
